// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog timer: FSM state encoding,
// register byte offsets and the default counter width.
package wdt_pkg;

  localparam int WDT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_RST_REQ = 2'd3
  } wdt_state_e;

  localparam logic [4:0] WDT_WDEN   = 5'h00;
  localparam logic [4:0] WDT_WDLIVE = 5'h04;
  localparam logic [4:0] WDT_WTOCNT = 5'h08;
  localparam logic [4:0] WDT_WDSTAT = 5'h0C;
  localparam logic [4:0] WDT_WDCNT  = 5'h10;

  // Word-granular address match; the byte lane bits [1:0] are ignored.
  function automatic logic wdt_addr_hit(input logic [4:0] addr, input logic [4:0] offset);
    return addr[4:2] == offset[4:2];
  endfunction

endpackage

// File: rtl/wdt_timer_if.sv
// Peripheral register bus seen by the watchdog: single-cycle write strobe
// plus combinational read data for the presented address.
interface wdt_timer_if;

  logic        i_wr_en;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;

  modport master (output i_wr_en, output i_addr, output i_wdata, input o_rdata);
  modport slave  (input i_wr_en, input i_addr, input i_wdata, output o_rdata);

endinterface

// File: rtl/wdt_timer.sv
// Watchdog timer: programmable timeout, software kick, level interrupt on
// expiry. Define WDT_RST_REQ_EN to add a second-stage timeout that raises a
// sticky system reset request (o_rst_req), cleared only by rst_n.
module wdt_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W = WDT_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  wdt_timer_if.slave  bus,
  output logic        o_intr_wdt
`ifdef WDT_RST_REQ_EN
  ,
  output logic        o_rst_req
`endif
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wtocnt_q;
  logic             wden_q;
  logic             intr_q;
  logic             rst_req_q;

  logic wr_wden, wr_wtocnt, kick, en_set, en_clr, cnt_hit;
  logic unused_addr_bits;

  assign wr_wden   = bus.i_wr_en && wdt_addr_hit(bus.i_addr, WDT_WDEN);
  assign wr_wtocnt = bus.i_wr_en && wdt_addr_hit(bus.i_addr, WDT_WTOCNT);
  assign kick      = bus.i_wr_en && wdt_addr_hit(bus.i_addr, WDT_WDLIVE) && bus.i_wdata[0];
  assign en_set    = wr_wden && bus.i_wdata[0];
  assign en_clr    = wr_wden && !bus.i_wdata[0];
  // Compare against the timeout registered before this edge, never the write data.
  assign cnt_hit   = (cnt_q == wtocnt_q);

  assign unused_addr_bits = &{1'b0, bus.i_addr[1:0]};

  // Software-visible configuration registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wden_q   <= 1'b0;
      wtocnt_q <= '0;
    end else begin
      if (wr_wden)   wden_q   <= bus.i_wdata[0];
      if (wr_wtocnt) wtocnt_q <= CNT_W'(bus.i_wdata);
    end
  end

  // Next-state and counter logic; earlier branches take priority.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_RST_REQ) begin
      // Terminal until reset: kick and disable are ignored.
      cnt_d = '0;
    end else if (en_clr && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (kick && state_q != ST_IDLE) begin
      state_d = ST_COUNT;
      cnt_d   = '0;
    end else if (en_set && state_q == ST_IDLE) begin
      state_d = ST_COUNT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (cnt_hit) begin
            state_d = ST_EXPIRED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_EXPIRED: begin
`ifdef WDT_RST_REQ_EN
          if (cnt_hit) begin
            state_d = ST_RST_REQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // FSM, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intr_q  <= (state_d == ST_EXPIRED) || (state_d == ST_RST_REQ);
    end
  end

`ifdef WDT_RST_REQ_EN
  // Sticky reset request; only rst_n brings the FSM out of RST_REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_req_q <= 1'b0;
    else        rst_req_q <= (state_d == ST_RST_REQ);
  end

  assign o_rst_req = rst_req_q;
`else
  assign rst_req_q = 1'b0;
`endif

  assign o_intr_wdt = intr_q;

  // Combinational register read mux; unmapped and write-only offsets read 0.
  always_comb begin
    bus.o_rdata = '0;
    if (wdt_addr_hit(bus.i_addr, WDT_WDEN)) begin
      bus.o_rdata = {31'd0, wden_q};
    end else if (wdt_addr_hit(bus.i_addr, WDT_WTOCNT)) begin
      bus.o_rdata = 32'(wtocnt_q);
    end else if (wdt_addr_hit(bus.i_addr, WDT_WDSTAT)) begin
      bus.o_rdata = {28'd0, rst_req_q, intr_q, state_q};
    end else if (wdt_addr_hit(bus.i_addr, WDT_WDCNT)) begin
      bus.o_rdata = 32'(cnt_q);
    end
  end

endmodule
